// File: rtl/sdp_ram_arb2_pkg.sv
// Shared constants and types for the two-requester SDP RAM access controller.
package sdp_ram_arb_pkg;

    localparam int unsigned AW_C  = 9;
    localparam int unsigned DW_C  = 32;
    localparam int unsigned NBE_C = 4;

    localparam logic [AW_C-1:0] FILL_LAST_C = 9'd511;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_e;

endpackage

// File: rtl/sdp_ram_arb2_if.sv
// Requester-side request/grant bundle; the controller takes one slave view per requester.
interface sdp_ram_arb2_if #(
    parameter int unsigned AW = sdp_ram_arb_pkg::AW_C,
    parameter int unsigned DW = sdp_ram_arb_pkg::DW_C
);

    logic            req;
    logic            we;
    logic [DW/8-1:0] be;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   wdata;
    logic            gnt;
    logic            rvalid;

    modport master (
        output req, we, be, addr, wdata,
        input  gnt, rvalid
    );

    modport slave (
        input  req, we, be, addr, wdata,
        output gnt, rvalid
    );

endinterface

// File: rtl/sdp_ram_arb2_rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the preferred requester.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic [1:0] gnt_o
);

    logic ptr_q, ptr_d;

    // After any grant the pointer lands on the requester that was not served.
    always_comb begin
        gnt_o = 2'b00;
        ptr_d = ptr_q;
        if (en_i) begin
            if (req_i[ptr_q]) begin
                gnt_o[ptr_q] = 1'b1;
                ptr_d        = ~ptr_q;
            end else if (req_i[~ptr_q]) begin
                gnt_o[~ptr_q] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/sdp_ram_arb2.sv
// Arbitrates two requesters onto the write port and the registered-address read port of
// a byte-enabled simple-dual-port RAM, after an optional zero-fill following reset.
module sdp_ram_arb2
    import sdp_ram_arb_pkg::*;
#(
    parameter int unsigned AW         = AW_C,
    parameter int unsigned DW         = DW_C,
    parameter bit          INIT_CLEAR = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    sdp_ram_arb2_if.slave   r0,
    sdp_ram_arb2_if.slave   r1,
    output logic [DW-1:0]   rdata,
    output logic            init_done,
    output logic [DW/8-1:0] ram_wea,
    output logic [AW-1:0]   ram_addra,
    output logic [DW-1:0]   ram_dina,
    output logic [AW-1:0]   ram_addrb,
    input  logic [DW-1:0]   ram_doutb
);

    state_e        state_q, state_d;
    logic [AW-1:0] fc_q, fc_d;
    logic [AW-1:0] addrb_q;
    logic [1:0]    rv_q;
    logic [1:0]    wr_req, rd_req, wr_gnt, rd_gnt;
    logic          run;

    // Outputs are held quiet while rst is high, whatever state the registers hold.
    assign run       = (state_q == ST_RUN) && !rst;
    assign init_done = run;

    assign wr_req = {r1.req & r1.we, r0.req & r0.we};
    assign rd_req = {r1.req & ~r1.we, r0.req & ~r0.we};

    rr_arb2 u_wr_arb (
        .clk   (clk),
        .rst   (rst),
        .req_i (wr_req),
        .en_i  (run),
        .gnt_o (wr_gnt)
    );

    rr_arb2 u_rd_arb (
        .clk   (clk),
        .rst   (rst),
        .req_i (rd_req),
        .en_i  (run),
        .gnt_o (rd_gnt)
    );

    assign r0.gnt    = wr_gnt[0] | rd_gnt[0];
    assign r1.gnt    = wr_gnt[1] | rd_gnt[1];
    assign r0.rvalid = rv_q[0] & ~rst;
    assign r1.rvalid = rv_q[1] & ~rst;
    assign rdata     = ram_doutb;

    always_comb begin
        state_d = state_q;
        fc_d    = fc_q;
        if (state_q == ST_INIT && !rst) begin
            fc_d = fc_q + 1'b1;
            if (fc_q == AW'(FILL_LAST_C)) begin
                state_d = ST_RUN;
            end
        end
    end

    always_comb begin
        ram_wea   = '0;
        ram_addra = fc_q;
        ram_dina  = '0;
        if (state_q == ST_INIT) begin
            if (!rst) begin
                ram_wea = '1;
            end
        end else if (wr_gnt[1]) begin
            ram_wea   = r1.be;
            ram_addra = r1.addr;
            ram_dina  = r1.wdata;
        end else if (wr_gnt[0]) begin
            ram_wea   = r0.be;
            ram_addra = r0.addr;
            ram_dina  = r0.wdata;
        end
    end

    // The RAM registers ram_addrb itself, so the granted address must be visible this cycle.
    always_comb begin
        ram_addrb = addrb_q;
        if (rd_gnt[1]) begin
            ram_addrb = r1.addr;
        end else if (rd_gnt[0]) begin
            ram_addrb = r0.addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT_CLEAR ? ST_INIT : ST_RUN;
            fc_q    <= '0;
            addrb_q <= '0;
            rv_q    <= 2'b00;
        end else begin
            state_q <= state_d;
            fc_q    <= fc_d;
            addrb_q <= ram_addrb;
            rv_q    <= rd_gnt;
        end
    end

endmodule

// File: tb/tb_sdp_ram_arb2.sv
// Scoreboard bench for sdp_ram_arb2 with a behavioural byte-enabled SDP RAM attached.
module tb_sdp_ram_arb2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sdp_ram_arb2_if r0_if ();
    sdp_ram_arb2_if r1_if ();
    sdp_ram_arb2_if n0_if ();
    sdp_ram_arb2_if n1_if ();

    logic [31:0] rdata, ram_dina, ram_doutb;
    logic [8:0]  ram_addra, ram_addrb;
    logic [3:0]  ram_wea;
    logic        init_done;
    logic [31:0] nc_rdata, nc_dina;
    logic [8:0]  nc_addra, nc_addrb;
    logic [3:0]  nc_wea;
    logic        nc_init_done;

    sdp_ram_arb2 #(.AW(9), .DW(32), .INIT_CLEAR(1'b1)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .r0        (r0_if),
        .r1        (r1_if),
        .rdata     (rdata),
        .init_done (init_done),
        .ram_wea   (ram_wea),
        .ram_addra (ram_addra),
        .ram_dina  (ram_dina),
        .ram_addrb (ram_addrb),
        .ram_doutb (ram_doutb)
    );

    sdp_ram_arb2 #(.AW(9), .DW(32), .INIT_CLEAR(1'b0)) u_dut_nc (
        .clk       (clk),
        .rst       (rst),
        .r0        (n0_if),
        .r1        (n1_if),
        .rdata     (nc_rdata),
        .init_done (nc_init_done),
        .ram_wea   (nc_wea),
        .ram_addra (nc_addra),
        .ram_dina  (nc_dina),
        .ram_addrb (nc_addrb),
        .ram_doutb (32'h0)
    );

    // RAM: port B write-first against a same-edge port-A write, output registered.
    logic [31:0] mem [512];
    logic [31:0] rd_nxt;
    logic        mem_init = 1'b0;

    always_comb begin
        rd_nxt = mem[ram_addrb];
        for (int b = 0; b < 4; b++) begin
            if (ram_wea[b] && ram_addra == ram_addrb) rd_nxt[b*8 +: 8] = ram_dina[b*8 +: 8];
        end
    end

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 512; i++) mem[i] <= 32'hA5A5_0000 | i;
            mem_init <= 1'b1;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (ram_wea[b]) mem[ram_addra][b*8 +: 8] <= ram_dina[b*8 +: 8];
            end
        end
        ram_doutb <= rd_nxt;
    end

    typedef struct packed {
        logic        id;
        logic [31:0] data;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    always @(negedge clk) begin
        if (r0_if.rvalid || r1_if.rvalid) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: rvalid r1/r0=%b%b, required no rvalid",
                         r1_if.rvalid, r0_if.rvalid);
            end else begin
                mon_e = sb_q.pop_front();
                if ({r1_if.rvalid, r0_if.rvalid} !== (mon_e.id ? 2'b10 : 2'b01) ||
                    rdata !== mon_e.data) begin
                    errors++;
                    $display("FAIL sb_read: rvalid r1/r0=%b%b rdata=%h, required r%0d rdata=%h",
                             r1_if.rvalid, r0_if.rvalid, rdata, mon_e.id, mon_e.data);
                end
            end
        end
    end

    task automatic drive(input bit id, input logic req, input logic we, input logic [3:0] be,
                         input logic [8:0] addr, input logic [31:0] wd);
        if (!id) begin
            r0_if.req = req; r0_if.we = we; r0_if.be = be; r0_if.addr = addr; r0_if.wdata = wd;
        end else begin
            r1_if.req = req; r1_if.we = we; r1_if.be = be; r1_if.addr = addr; r1_if.wdata = wd;
        end
    endtask

    task automatic idle_all();
        drive(1'b0, 1'b0, 1'b0, 4'h0, 9'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 4'h0, 9'h0, 32'h0);
    endtask

    task automatic test_reset();
        int fill_bad = 0;
        int gate_bad = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({r1_if.gnt, r0_if.gnt, r1_if.rvalid, r0_if.rvalid, init_done} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: gnt=%b%b rvalid=%b%b init_done=%b, required all 0",
                     r1_if.gnt, r0_if.gnt, r1_if.rvalid, r0_if.rvalid, init_done);
        end
        checks++;
        if (ram_wea !== 4'h0 || ram_addrb !== 9'h0) begin
            errors++;
            $display("FAIL reset_ram: wea=%h addrb=%h, required 0 0", ram_wea, ram_addrb);
        end
        checks++;
        if (nc_init_done !== 1'b0) begin
            errors++;
            $display("FAIL nc_reset_done: init_done=%b, required 0", nc_init_done);
        end
        drive(1'b0, 1'b1, 1'b0, 4'h0, 9'h1FF, 32'h0);
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 512; i++) begin
            @(negedge clk);
            if (ram_wea !== 4'hF || ram_addra !== 9'(i) || ram_dina !== 32'h0) fill_bad++;
            if (init_done !== 1'b0 || r0_if.gnt !== 1'b0) gate_bad++;
            if (i == 0) begin
                checks++;
                if (nc_init_done !== 1'b1) begin
                    errors++;
                    $display("FAIL nc_done_cycle1: init_done=%b, required 1", nc_init_done);
                end
            end
        end
        checks++;
        if (fill_bad != 0) begin
            errors++;
            $display("FAIL fill_writes: %0d bad cycles, required 0", fill_bad);
        end
        checks++;
        if (gate_bad != 0) begin
            errors++;
            $display("FAIL fill_gating: %0d cycles with gnt/init_done, required 0", gate_bad);
        end
        @(negedge clk);
        checks++;
        if (init_done !== 1'b1 || r0_if.gnt !== 1'b1 || ram_addrb !== 9'h1FF) begin
            errors++;
            $display("FAIL first_grant: init_done=%b gnt=%b addrb=%h, required 1 1 1ff",
                     init_done, r0_if.gnt, ram_addrb);
        end
        sb_q.push_back('{id: 1'b0, data: 32'h0});
        @(posedge clk); #1 idle_all();
        @(negedge clk);
        checks++;
        if (r0_if.rvalid !== 1'b1) begin
            errors++;
            $display("FAIL fill_read_latency: r0_rvalid=%b, required 1", r0_if.rvalid);
        end
    endtask

    task automatic test_rr_writes();
        logic [8:0]  a0 = 9'h20;
        logic [8:0]  a1 = 9'h30;
        logic [31:0] d0 = 32'h1111_0000;
        logic [31:0] d1 = 32'h2222_0000;
        logic        exp_id = 1'b0;
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b1, 4'hF, a0, d0);
        drive(1'b1, 1'b1, 1'b1, 4'hF, a1, d1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({r1_if.gnt, r0_if.gnt} !== (exp_id ? 2'b10 : 2'b01) || ram_wea !== 4'hF ||
                ram_addra !== (exp_id ? a1 : a0) || ram_dina !== (exp_id ? d1 : d0)) begin
                errors++;
                $display("FAIL rr_write%0d: gnt=%b%b addra=%h dina=%h, required r%0d %h %h", i,
                         r1_if.gnt, r0_if.gnt, ram_addra, ram_dina, exp_id,
                         exp_id ? a1 : a0, exp_id ? d1 : d0);
            end
            @(posedge clk); #1;
            if (exp_id) begin
                a1++; d1++;
                drive(1'b1, 1'b1, 1'b1, 4'hF, a1, d1);
            end else begin
                a0++; d0++;
                drive(1'b0, 1'b1, 1'b1, 4'hF, a0, d0);
            end
            exp_id = ~exp_id;
        end
        idle_all();
        drive(1'b1, 1'b1, 1'b0, 4'h0, 9'h30, 32'h0);
        @(negedge clk);
        checks++;
        if (r1_if.gnt !== 1'b1) begin
            errors++;
            $display("FAIL rr_readback_gnt: r1_gnt=%b, required 1", r1_if.gnt);
        end
        sb_q.push_back('{id: 1'b1, data: 32'h2222_0000});
        @(posedge clk); #1 idle_all();
        @(negedge clk);
    endtask

    task automatic test_write_be();
        @(posedge clk); #1 drive(1'b0, 1'b1, 1'b1, 4'b0101, 9'h005, 32'hDEAD_BEEF);
        @(negedge clk);
        checks++;
        if (r0_if.gnt !== 1'b1 || ram_wea !== 4'b0101 || ram_addra !== 9'h005 ||
            ram_dina !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL be_write: gnt=%b wea=%b addra=%h dina=%h, required 1 0101 005 deadbeef",
                     r0_if.gnt, ram_wea, ram_addra, ram_dina);
        end
        @(posedge clk); #1 drive(1'b0, 1'b1, 1'b0, 4'h0, 9'h005, 32'h0);
        @(negedge clk);
        checks++;
        if (r0_if.gnt !== 1'b1 || ram_addrb !== 9'h005) begin
            errors++;
            $display("FAIL be_read_gnt: gnt=%b addrb=%h, required 1 005", r0_if.gnt, ram_addrb);
        end
        sb_q.push_back('{id: 1'b0, data: 32'h00AD_00EF});
        @(posedge clk); #1 idle_all();
        @(negedge clk);
        checks++;
        if (r0_if.rvalid !== 1'b1 || r1_if.rvalid !== 1'b0) begin
            errors++;
            $display("FAIL be_read_latency: rvalid r1/r0=%b%b, required 01",
                     r1_if.rvalid, r0_if.rvalid);
        end
        @(negedge clk);
        checks++;
        if (r0_if.rvalid !== 1'b0) begin
            errors++;
            $display("FAIL be_rvalid_pulse: r0_rvalid=%b, required 0", r0_if.rvalid);
        end
    endtask

    task automatic test_same_cycle();
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b1, 4'hF, 9'h010, 32'h1234_5678);
        drive(1'b1, 1'b1, 1'b0, 4'h0, 9'h010, 32'h0);
        @(negedge clk);
        checks++;
        if ({r1_if.gnt, r0_if.gnt} !== 2'b11) begin
            errors++;
            $display("FAIL rw_same_gnt: gnt=%b%b, required 11", r1_if.gnt, r0_if.gnt);
        end
        sb_q.push_back('{id: 1'b1, data: 32'h1234_5678});
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b1, 4'hF, 9'h010, 32'hAAAA_AAAA);
        drive(1'b1, 1'b0, 1'b0, 4'h0, 9'h0, 32'h0);
        @(negedge clk);
        checks++;
        if (r1_if.rvalid !== 1'b1 || r0_if.gnt !== 1'b1) begin
            errors++;
            $display("FAIL rw_same_rvalid: r1_rvalid=%b r0_gnt=%b, required 1 1",
                     r1_if.rvalid, r0_if.gnt);
        end
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b0, 4'h0, 9'h010, 32'h0);
        drive(1'b1, 1'b1, 1'b1, 4'h0, 9'h010, 32'h5555_5555);
        @(negedge clk);
        checks++;
        if ({r1_if.gnt, r0_if.gnt} !== 2'b11 || ram_wea !== 4'h0) begin
            errors++;
            $display("FAIL be0_write: gnt=%b%b wea=%h, required 11 0",
                     r1_if.gnt, r0_if.gnt, ram_wea);
        end
        sb_q.push_back('{id: 1'b0, data: 32'hAAAA_AAAA});
        @(posedge clk); #1 drive(1'b1, 1'b0, 1'b0, 4'h0, 9'h0, 32'h0);
        @(negedge clk);
        checks++;
        if (r0_if.gnt !== 1'b1 || r0_if.rvalid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_read: gnt=%b rvalid=%b, required 1 1", r0_if.gnt, r0_if.rvalid);
        end
        sb_q.push_back('{id: 1'b0, data: 32'hAAAA_AAAA});
        @(posedge clk); #1 idle_all();
        @(negedge clk);
    endtask

    task automatic test_read_contention();
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b0, 4'h0, 9'h005, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 4'h0, 9'h010, 32'h0);
        @(negedge clk);
        checks++;
        if ({r1_if.gnt, r0_if.gnt} !== 2'b10) begin
            errors++;
            $display("FAIL rd_rr0: gnt=%b%b, required 10", r1_if.gnt, r0_if.gnt);
        end
        sb_q.push_back('{id: 1'b1, data: 32'hAAAA_AAAA});
        @(posedge clk); #1 drive(1'b1, 1'b1, 1'b0, 4'h0, 9'h020, 32'h0);
        @(negedge clk);
        checks++;
        if ({r1_if.gnt, r0_if.gnt} !== 2'b01) begin
            errors++;
            $display("FAIL rd_rr1: gnt=%b%b, required 01", r1_if.gnt, r0_if.gnt);
        end
        sb_q.push_back('{id: 1'b0, data: 32'h00AD_00EF});
        @(posedge clk); #1 drive(1'b0, 1'b0, 1'b0, 4'h0, 9'h0, 32'h0);
        @(negedge clk);
        checks++;
        if ({r1_if.gnt, r0_if.gnt} !== 2'b10) begin
            errors++;
            $display("FAIL rd_rr2: gnt=%b%b, required 10", r1_if.gnt, r0_if.gnt);
        end
        sb_q.push_back('{id: 1'b1, data: 32'h1111_0000});
        @(posedge clk); #1 idle_all();
        @(negedge clk);
    endtask

    task automatic test_reset_read_inflight();
        @(posedge clk); #1 drive(1'b0, 1'b1, 1'b0, 4'h0, 9'h005, 32'h0);
        @(negedge clk);
        checks++;
        if (r0_if.gnt !== 1'b1) begin
            errors++;
            $display("FAIL squash_gnt: r0_gnt=%b, required 1", r0_if.gnt);
        end
        @(posedge clk); #1;
        idle_all();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({r1_if.rvalid, r0_if.rvalid} !== 2'b00 || init_done !== 1'b0) begin
            errors++;
            $display("FAIL squash_rvalid: rvalid=%b%b init_done=%b, required 00 0",
                     r1_if.rvalid, r0_if.rvalid, init_done);
        end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({r1_if.rvalid, r0_if.rvalid} !== 2'b00 || ram_addrb !== 9'h0 ||
            ram_wea !== 4'hF || ram_addra !== 9'h0) begin
            errors++;
            $display("FAIL squash_after: rvalid=%b%b addrb=%h wea=%h addra=%h, required 00 0 f 0",
                     r1_if.rvalid, r0_if.rvalid, ram_addrb, ram_wea, ram_addra);
        end
    endtask

    task automatic test_reset_mid_fill();
        int bad = 0;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ram_wea !== 4'hF || ram_addra !== 9'(i)) bad++;
        end
        rst = 1'b1;
        #1;
        checks++;
        if (ram_wea !== 4'h0) begin
            errors++;
            $display("FAIL midfill_rst_wea: wea=%h, required 0", ram_wea);
        end
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 512; i++) begin
            @(negedge clk);
            if (ram_wea !== 4'hF || ram_addra !== 9'(i) || init_done !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL midfill_restart: %0d bad cycles, required 0", bad);
        end
        @(negedge clk);
        checks++;
        if (init_done !== 1'b1) begin
            errors++;
            $display("FAIL midfill_done: init_done=%b, required 1", init_done);
        end
    endtask

    initial begin
        idle_all();
        n0_if.req = 1'b0; n0_if.we = 1'b0; n0_if.be = 4'h0; n0_if.addr = 9'h0;
        n0_if.wdata = 32'h0;
        n1_if.req = 1'b0; n1_if.we = 1'b0; n1_if.be = 4'h0; n1_if.addr = 9'h0;
        n1_if.wdata = 32'h0;
        test_reset();
        test_rr_writes();
        test_write_be();
        test_same_cycle();
        test_read_contention();
        test_reset_read_inflight();
        test_reset_mid_fill();
        @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d reads outstanding, required 0", sb_q.size());
        end
        checks++;
        if (nc_wea !== 4'h0 || nc_addrb !== 9'h0) begin
            errors++;
            $display("FAIL nc_idle: wea=%h addrb=%h, required 0 0", nc_wea, nc_addrb);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
